// File: rtl/mem_byte_lane_pkg.sv
// Shared encodings for the byte-lane memory controller: access sizes, lane count, pipeline states.
package mem_byte_lane_pkg;

    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'd0,
        SIZE_HALF    = 2'd1,
        SIZE_WORD    = 2'd2,
        SIZE_ILLEGAL = 2'd3
    } size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            default:   size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load realignment: gathers rotated lane bytes into LSB-justified data and sign/zero-extends.
module mem_load_align
    import mem_byte_lane_pkg::*;
(
    input  logic        en,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] lane_dout,
    output logic [31:0] rdata
);

    logic [31:0] gathered;
    logic [1:0]  lane;

    always_comb begin
        gathered = '0;
        lane     = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane = offset + 2'(i);
            if (i < 32'(size_bytes(size)))
                gathered[i*8 +: 8] = lane_dout[lane*8 +: 8];
        end
        case (size)
            SIZE_BYTE: rdata = {{24{~is_unsigned & gathered[7]}}, gathered[7:0]};
            SIZE_HALF: rdata = {{16{~is_unsigned & gathered[15]}}, gathered[15:0]};
            default:   rdata = gathered;
        endcase
        if (!en)
            rdata = '0;
    end

endmodule

// File: rtl/mem_byte_lane_ctrl.sv
// Byte/half/word load-store controller over four byte-wide RAM lanes.
// Define MEM_BYTE_LANE_MISALIGN_EN to support misaligned half/word accesses.
module mem_byte_lane_ctrl
    import mem_byte_lane_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 14
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        req,
    output logic                        req_ready,
    input  logic                        req_we,
    input  logic [1:0]                  req_size,
    input  logic                        req_unsigned,
    input  logic [ADDR_WIDTH+1:0]       req_addr,
    input  logic [31:0]                 req_wdata,
    output logic [4*ADDR_WIDTH-1:0]     lane_addr,
    output logic [31:0]                 lane_din,
    output logic [3:0]                  lane_we,
    input  logic [31:0]                 lane_dout,
    output logic                        ack,
    output logic                        ack_err,
    output logic [31:0]                 rdata
);

    logic [1:0]            offset;
    logic [ADDR_WIDTH-1:0] word;
    logic                  accept;
    logic                  illegal;
    logic [1:0]            lane;

    state_e     state;
    logic       err_q;
    logic       load_q;
    logic       uns_q;
    logic [1:0] off_q;
    logic [1:0] size_q;

    assign offset    = req_addr[1:0];
    assign word      = req_addr[ADDR_WIDTH+1:2];
    assign req_ready = ~reset;
    assign accept    = req & req_ready;

    always_comb begin
        illegal = (req_size == SIZE_ILLEGAL);
`ifndef MEM_BYTE_LANE_MISALIGN_EN
        if (req_size == SIZE_HALF && offset[0])
            illegal = 1'b1;
        if (req_size == SIZE_WORD && offset != 2'd0)
            illegal = 1'b1;
`endif
    end

`ifdef MEM_BYTE_LANE_MISALIGN_EN
    logic [ADDR_WIDTH-1:0] word_next;

    // Lanes below the offset hold the bytes that spill into the next word.
    assign word_next = word + ADDR_WIDTH'(1);

    always_comb begin
        lane_addr = '0;
        for (int unsigned k = 0; k < LANES; k++)
            lane_addr[k*ADDR_WIDTH +: ADDR_WIDTH] = (2'(k) < offset) ? word_next : word;
    end
`else
    assign lane_addr = {LANES{word}};
`endif

    always_comb begin
        lane_we  = '0;
        lane_din = '0;
        lane     = '0;
        if (accept && req_we && !illegal) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lane = offset + 2'(i);
                if (i < 32'(size_bytes(req_size))) begin
                    lane_we[lane]          = 1'b1;
                    lane_din[lane*8 +: 8]  = req_wdata[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            err_q  <= 1'b0;
            load_q <= 1'b0;
            uns_q  <= 1'b0;
            off_q  <= '0;
            size_q <= '0;
        end else begin
            state  <= accept ? ST_RESP : ST_IDLE;
            err_q  <= accept & illegal;
            load_q <= accept & ~req_we & ~illegal;
            if (accept) begin
                uns_q  <= req_unsigned;
                off_q  <= offset;
                size_q <= req_size;
            end
        end
    end

    // Gating with reset drops a response whose request was accepted just before reset.
    assign ack     = (state == ST_RESP) & ~reset;
    assign ack_err = err_q & ack;

    mem_load_align u_load_align (
        .en          (load_q & ack),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .lane_dout   (lane_dout),
        .rdata       (rdata)
    );

endmodule

// File: tb/tb_mem_byte_lane_ctrl.sv
// Bench for mem_byte_lane_ctrl: byte-addressed reference memory plus response scoreboard.
module tb_mem_byte_lane_ctrl;

    localparam int unsigned AW = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              req;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [AW+1:0]     req_addr;
    logic [31:0]       req_wdata;
    logic [4*AW-1:0]   lane_addr;
    logic [31:0]       lane_din;
    logic [3:0]        lane_we;
    logic [31:0]       lane_dout;
    logic              ack;
    logic              ack_err;
    logic [31:0]       rdata;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t       exp_q[$];
    logic [7:0]  ref_mem [256] = '{default: 8'h00};
    logic [7:0]  lane_mem [4][64] = '{default: '{default: 8'h00}};
    logic [AW-1:0] raddr_q [4] = '{default: '0};
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mem_byte_lane_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .lane_addr    (lane_addr),
        .lane_din     (lane_din),
        .lane_we      (lane_we),
        .lane_dout    (lane_dout),
        .ack          (ack),
        .ack_err      (ack_err),
        .rdata        (rdata)
    );

    // Four byte RAMs with registered read address.
    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_we[k])
                lane_mem[k][lane_addr[k*AW +: AW]] <= lane_din[k*8 +: 8];
            raddr_q[k] <= lane_addr[k*AW +: AW];
        end
    end

    always_comb begin
        lane_dout = '0;
        for (int k = 0; k < 4; k++)
            lane_dout[k*8 +: 8] = lane_mem[k][raddr_q[k]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        resp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("resp_ack", {31'd0, ack}, 32'd1);
            check("resp_err", {31'd0, ack_err}, {31'd0, e.err});
            check("resp_rdata", rdata, e.data);
        end else begin
            check("idle_ack", {31'd0, ack}, 32'd0);
            check("idle_rdata", rdata, 32'd0);
        end
    end

    // Called at posedge+1; drives one request for a cycle and returns at the next posedge+1.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [7:0] addr, input logic [31:0] wdata,
                          output logic [3:0] we_seen, output logic [31:0] din_seen,
                          output logic [4*AW-1:0] addr_seen);
        int           n;
        logic         legal;
        logic [7:0]   a;
        logic [3:0]   exp_we;
        logic [31:0]  exp_din;
        logic [4*AW-1:0] exp_addr;
        logic [4*AW-1:0] mask;
        logic [31:0]  raw;
        resp_t        r;

        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        legal = (size != 2'd3);
`ifndef MEM_BYTE_LANE_MISALIGN_EN
        if (size == 2'd1 && addr[0]) legal = 1'b0;
        if (size == 2'd2 && addr[1:0] != 2'd0) legal = 1'b0;
`endif
        exp_we = '0; exp_din = '0; exp_addr = '0; mask = '0;
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                a = addr + 8'(i);
                exp_addr[a[1:0]*AW +: AW] = a[7:2];
                mask[a[1:0]*AW +: AW]     = '1;
                if (we) begin
                    exp_we[a[1:0]]          = 1'b1;
                    exp_din[a[1:0]*8 +: 8]  = wdata[i*8 +: 8];
                end
            end
        end

        req = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        #1;
        we_seen = lane_we; din_seen = lane_din; addr_seen = lane_addr;
        check({tag, "_we"}, {28'd0, lane_we}, {28'd0, exp_we});
        check({tag, "_din"}, lane_din, exp_din);
        check({tag, "_addr"}, 32'(lane_addr & mask), 32'(exp_addr));
        @(posedge clk);

        raw = '0;
        for (int i = 0; i < n; i++)
            raw[i*8 +: 8] = ref_mem[8'(addr + 8'(i))];
        r.err = ~legal;
        if (!legal || we)
            r.data = '0;
        else if (n == 1)
            r.data = {{24{~uns & raw[7]}}, raw[7:0]};
        else if (n == 2)
            r.data = {{16{~uns & raw[15]}}, raw[15:0]};
        else
            r.data = raw;
        exp_q.push_back(r);
        if (legal && we)
            for (int i = 0; i < n; i++)
                ref_mem[8'(addr + 8'(i))] = wdata[i*8 +: 8];
        #1;
        req = 1'b0;
    endtask

    initial begin
        logic [3:0]      we_s;
        logic [31:0]     din_s;
        logic [4*AW-1:0] addr_s;

        reset = 1'b1; req = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_lane_we", {28'd0, lane_we}, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        req = 1'b0;
        reset = 1'b0;

        do_req("st_word", 1'b1, 2'd2, 1'b0, 8'h10, 32'hDEAD_BEEF, we_s, din_s, addr_s);
        check("st_word_we_const", {28'd0, we_s}, 32'h0000_000F);
        do_req("ld_word", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, we_s, din_s, addr_s);

        do_req("st_byte", 1'b1, 2'd0, 1'b0, 8'h13, 32'h0000_0080, we_s, din_s, addr_s);
        check("st_byte_we_const", {28'd0, we_s}, 32'h0000_0008);
        do_req("ld_sbyte", 1'b0, 2'd0, 1'b0, 8'h13, 32'h0, we_s, din_s, addr_s);
        do_req("ld_ubyte", 1'b0, 2'd0, 1'b1, 8'h13, 32'h0, we_s, din_s, addr_s);

        for (int o = 0; o < 4; o++)
            do_req("st_lane", 1'b1, 2'd0, 1'b0, 8'(8'h30 + o), 32'(8'hF0 + o), we_s, din_s, addr_s);
        do_req("ld_lanes", 1'b0, 2'd2, 1'b1, 8'h30, 32'h0, we_s, din_s, addr_s);

        do_req("st_half", 1'b1, 2'd1, 1'b0, 8'h26, 32'h0000_8001, we_s, din_s, addr_s);
        do_req("ld_shalf", 1'b0, 2'd1, 1'b0, 8'h26, 32'h0, we_s, din_s, addr_s);
        do_req("ld_uhalf", 1'b0, 2'd1, 1'b1, 8'h26, 32'h0, we_s, din_s, addr_s);

`ifdef MEM_BYTE_LANE_MISALIGN_EN
        do_req("st_mis", 1'b1, 2'd2, 1'b0, 8'h07, 32'h1122_3344, we_s, din_s, addr_s);
        check("st_mis_din_const", din_s, 32'h4411_2233);
        check("st_mis_addr_const", 32'(addr_s), 32'({6'd1, 6'd2, 6'd2, 6'd2}));
        do_req("ld_mis", 1'b0, 2'd2, 1'b0, 8'h07, 32'h0, we_s, din_s, addr_s);
        do_req("st_wrap", 1'b1, 2'd1, 1'b0, 8'hFF, 32'h0000_A5A5, we_s, din_s, addr_s);
        check("st_wrap_we_const", {28'd0, we_s}, 32'h0000_0009);
        check("st_wrap_addr_l3", {26'd0, addr_s[3*AW +: AW]}, 32'd63);
        check("st_wrap_addr_l0", {26'd0, addr_s[0 +: AW]}, 32'd0);
        do_req("ld_wrap", 1'b0, 2'd1, 1'b0, 8'hFF, 32'h0, we_s, din_s, addr_s);
        do_req("ld_mis_half", 1'b0, 2'd1, 1'b1, 8'h09, 32'h0, we_s, din_s, addr_s);
`else
        do_req("ld_mis_word", 1'b0, 2'd2, 1'b0, 8'h02, 32'h0, we_s, din_s, addr_s);
        do_req("st_mis_half", 1'b1, 2'd1, 1'b0, 8'h11, 32'h0000_5555, we_s, din_s, addr_s);
        check("st_mis_half_we_const", {28'd0, we_s}, 32'd0);
        do_req("st_mis_word", 1'b1, 2'd2, 1'b0, 8'h13, 32'h7777_7777, we_s, din_s, addr_s);
        do_req("ld_after_rej", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, we_s, din_s, addr_s);
`endif

        do_req("st_size3", 1'b1, 2'd3, 1'b0, 8'h20, 32'h1234_5678, we_s, din_s, addr_s);
        check("st_size3_we_const", {28'd0, we_s}, 32'd0);
        do_req("ld_size3", 1'b0, 2'd3, 1'b0, 8'h10, 32'h0, we_s, din_s, addr_s);

        do_req("st_b2b", 1'b1, 2'd1, 1'b0, 8'h24, 32'h0000_1234, we_s, din_s, addr_s);
        do_req("ld_b2b", 1'b0, 2'd1, 1'b1, 8'h24, 32'h0, we_s, din_s, addr_s);

        do_req("ld_drop", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, we_s, din_s, addr_s);
        reset = 1'b1;
        exp_q.delete();
        req = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 8'h10; req_wdata = 32'h0BAD_0BAD;
        #1;
        check("rst_mid_we", {28'd0, lane_we}, 32'd0);
        check("rst_mid_ack", {31'd0, ack}, 32'd0);
        @(posedge clk);
        #1;
        req = 1'b0;
        reset = 1'b0;
        do_req("ld_after_rst", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, we_s, din_s, addr_s);

        repeat (2) @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
